wide_alu_seq: RTL and testbench



---
 rtl/wide_alu_seq.sv | 148 ++++++++++++++
 tb/tb_wide_alu_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wide_alu_seq.sv
// 16-bit ADD/SUB/SHL sequencer that drives an external 8-bit ALU one byte per cycle,
// low byte first, chaining the carry between byte passes.
package alu_defs_pkg;
    localparam logic [3:0] kADD = 4'h1;
    localparam logic [3:0] kSHL = 4'h6;
endpackage

module wide_alu_seq #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [1:0]       op_sel,
    input  logic [15:0]      opnd_a,
    input  logic [15:0]      opnd_b,
    input  logic [CNT_W-1:0] shamt,
    output logic             ready,
    output logic             done,
    output logic [15:0]      result,
    output logic             co16,
    output logic             z16,
    output logic             neg16,
    output logic             err,
    output logic [3:0]       alu_op,
    output logic [7:0]       alu_in_a,
    output logic [7:0]       alu_in_acc,
    output logic             alu_ci,
    input  logic [7:0]       alu_acc,
    input  logic             alu_co
);
    import alu_defs_pkg::*;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_SHL, OP_ILL} op_e;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_e           state, next_state;
    op_e              op_q, op_in;
    logic [15:0]      work_q;
    logic [15:0]      b_q;
    logic             carry_q;
    logic [CNT_W-1:0] count_q;

    assign op_in = op_e'(op_sel);
    assign ready = (state == IDLE);
    assign done  = (state == DONE);
    assign z16   = (result == 16'h0000);
    assign neg16 = result[15];

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        alu_op     = kADD;
        alu_in_a   = '0;
        alu_in_acc = '0;
        alu_ci     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (op_in == OP_ADD || op_in == OP_SUB)
                        next_state = LO;
                    else if (op_in == OP_SHL && shamt != '0)
                        next_state = LO;
                    else
                        next_state = DONE;
                end
            end
            LO: begin
                next_state = HI;
                alu_in_acc = work_q[7:0];
                if (op_q == OP_SHL) begin
                    alu_op   = kSHL;
                    alu_in_a = 8'd1;
                end else begin
                    alu_in_a = b_q[7:0];
                    alu_ci   = (op_q == OP_SUB);
                end
            end
            HI: begin
                alu_in_acc = work_q[15:8];
                alu_ci     = carry_q;
                if (op_q == OP_SHL) begin
                    alu_op   = kSHL;
                    alu_in_a = 8'd1;
                end else begin
                    alu_in_a = b_q[15:8];
                end
                if (op_q == OP_SHL && count_q > CNT_ONE)
                    next_state = LO;
                else
                    next_state = DONE;
            end
            DONE: next_state = IDLE;
        endcase
    end

    // result/co16 are loaded on entry to DONE so they are already valid while done is high
    always_ff @(posedge Clk) begin
        if (Reset) begin
            op_q    <= OP_ADD;
            work_q  <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            result  <= '0;
            co16    <= 1'b0;
            err     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q    <= op_in;
                        work_q  <= opnd_a;
                        b_q     <= (op_in == OP_SUB) ? ~opnd_b : opnd_b;
                        carry_q <= 1'b0;
                        count_q <= shamt;
                        err     <= (op_in == OP_ILL);
                        if (next_state == DONE) begin
                            result <= opnd_a;
                            co16   <= 1'b0;
                        end
                    end
                end
                LO: begin
                    work_q[7:0] <= alu_acc;
                    carry_q     <= alu_co;
                end
                HI: begin
                    work_q[15:8] <= alu_acc;
                    carry_q      <= alu_co;
                    if (next_state == LO) begin
                        count_q <= count_q - CNT_ONE;
                    end else begin
                        result <= {alu_acc, work_q[7:0]};
                        co16   <= alu_co;
                    end
                end
                DONE: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wide_alu_seq.sv
// Self-checking bench for wide_alu_seq: behavioural 8-bit ALU, directed vector table,
// reset/start-hold sequences and randomized ops checked against plain 16-bit arithmetic.
module tb_wide_alu_seq;
    import alu_defs_pkg::*;

    logic        Clk, Reset, start;
    logic [1:0]  op_sel;
    logic [15:0] opnd_a, opnd_b;
    logic [3:0]  shamt;
    logic        ready, done, co16, z16, neg16, err;
    logic [15:0] result;
    logic [3:0]  alu_op;
    logic [7:0]  alu_in_a, alu_in_acc, alu_acc;
    logic        alu_ci, alu_co;
    logic [16:0] alu_w;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    wide_alu_seq #(.CNT_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .op_sel(op_sel),
        .opnd_a(opnd_a), .opnd_b(opnd_b), .shamt(shamt),
        .ready(ready), .done(done), .result(result), .co16(co16),
        .z16(z16), .neg16(neg16), .err(err),
        .alu_op(alu_op), .alu_in_a(alu_in_a), .alu_in_acc(alu_in_acc),
        .alu_ci(alu_ci), .alu_acc(alu_acc), .alu_co(alu_co)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // 8-bit ALU: ADD with carry-in, SHL by in_a with ci filling bit 0
    always_comb begin
        alu_w   = '0;
        alu_acc = 8'h00;
        alu_co  = 1'b0;
        if (alu_op == kADD) begin
            {alu_co, alu_acc} = {1'b0, alu_in_acc} + {1'b0, alu_in_a} + {8'h00, alu_ci};
        end else if (alu_op == kSHL) begin
            alu_w   = {9'h000, alu_in_acc} << alu_in_a[3:0];
            alu_acc = alu_w[7:0] | {7'h00, alu_ci};
            alu_co  = alu_w[8];
        end else begin
            alu_acc = 8'hA5;
        end
    end

    always @(posedge Clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void ref_model(input logic [1:0] op, input logic [15:0] a, b,
                                      input logic [3:0] sh, output logic [15:0] res,
                                      output logic co, output logic e, output int lat);
        logic [16:0] s;
        logic [31:0] w;
        e = 1'b0;
        co = 1'b0;
        res = a;
        lat = 1;
        case (op)
            2'd0: begin s = {1'b0, a} + {1'b0, b}; res = s[15:0]; co = s[16]; lat = 3; end
            2'd1: begin s = {1'b0, a} + {1'b0, ~b} + 17'd1; res = s[15:0]; co = s[16]; lat = 3; end
            2'd2: begin
                if (sh != 0) begin
                    w = {16'h0000, a} << sh;
                    res = w[15:0];
                    co = w[16];
                    lat = 2 * int'(sh) + 1;
                end
            end
            default: e = 1'b1;
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [15:0] a, b, input logic [3:0] sh,
                          input bit hold_start, input string tag);
        logic [15:0] e_res;
        logic e_co, e_err;
        int e_lat, lat, waited, d0;
        bit busy_ready;
        ref_model(op, a, b, sh, e_res, e_co, e_err, e_lat);
        waited = 0;
        while (!ready && waited < 50) begin @(negedge Clk); waited++; end
        check({tag, " ready_before"}, ready, 1);
        start = 1'b1; op_sel = op; opnd_a = a; opnd_b = b; shamt = sh;
        d0 = done_cnt;
        @(posedge Clk);
        lat = 0;
        busy_ready = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clk);
            if (ready) busy_ready = 1;
            if (done) begin lat = c; break; end
            if (!hold_start) begin
                start  = 1'b0;
                op_sel = 2'($urandom);
                opnd_a = 16'($urandom);
                opnd_b = 16'($urandom);
                shamt  = 4'($urandom);
            end
        end
        check({tag, " latency"}, lat, e_lat);
        check({tag, " ready_busy"}, busy_ready, 0);
        check({tag, " result"}, result, e_res);
        check({tag, " co16"}, co16, e_co);
        check({tag, " z16"}, z16, (e_res == 16'h0000));
        check({tag, " neg16"}, neg16, e_res[15]);
        check({tag, " err"}, err, e_err);
        check({tag, " alu_idle"}, {alu_op, alu_in_a, alu_in_acc, alu_ci}, {kADD, 17'h0});
        start = 1'b0;
        @(negedge Clk);
        check({tag, " done_pulse"}, {done, ready}, 2'b01);
        check({tag, " result_hold"}, result, e_res);
        @(negedge Clk);
        check({tag, " done_count"}, done_cnt - d0, 1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a, b;
        logic [3:0]  sh;
        logic [15:0] exp_res;
        logic        exp_co, exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{2'd0, 16'h00FF, 16'h0001, 4'd0,  16'h0100, 1'b0, 1'b0, 3};
        vecs[1]  = '{2'd0, 16'hFFFF, 16'h0001, 4'd0,  16'h0000, 1'b1, 1'b0, 3};
        vecs[2]  = '{2'd1, 16'h1234, 16'h0235, 4'd0,  16'h0FFF, 1'b1, 1'b0, 3};
        vecs[3]  = '{2'd1, 16'h0001, 16'h0002, 4'd0,  16'hFFFF, 1'b0, 1'b0, 3};
        vecs[4]  = '{2'd2, 16'h1234, 16'h0000, 4'd4,  16'h2340, 1'b1, 1'b0, 9};
        vecs[5]  = '{2'd2, 16'h8001, 16'h0000, 4'd1,  16'h0002, 1'b1, 1'b0, 3};
        vecs[6]  = '{2'd2, 16'h1234, 16'hFFFF, 4'd0,  16'h1234, 1'b0, 1'b0, 1};
        vecs[7]  = '{2'd3, 16'hABCD, 16'h1111, 4'd5,  16'hABCD, 1'b0, 1'b1, 1};
        vecs[8]  = '{2'd0, 16'h1234, 16'h0000, 4'd7,  16'h1234, 1'b0, 1'b0, 3};
        vecs[9]  = '{2'd2, 16'h0001, 16'h0000, 4'd15, 16'h8000, 1'b0, 1'b0, 31};
        vecs[10] = '{2'd2, 16'hFFFF, 16'h0000, 4'd15, 16'h8000, 1'b1, 1'b0, 31};
        vecs[11] = '{2'd1, 16'h5555, 16'h5555, 4'd0,  16'h0000, 1'b1, 1'b0, 3};

        Reset = 1'b1; start = 1'b0; op_sel = '0; opnd_a = '0; opnd_b = '0; shamt = '0;
        repeat (3) @(negedge Clk);
        check("reset status", {ready, done, co16, z16, neg16, err}, 6'b100100);
        check("reset result", result, 16'h0000);
        check("reset alu", {alu_op, alu_in_a, alu_in_acc, alu_ci}, {kADD, 17'h0});
        Reset = 1'b0;
        @(negedge Clk);

        // table vectors: bench-side model must agree with hand-computed expectations
        for (int i = 0; i < 12; i++) begin
            logic [15:0] m_res;
            logic m_co, m_err;
            int m_lat;
            ref_model(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, m_res, m_co, m_err, m_lat);
            check($sformatf("vec%0d model", i), {m_res, m_co, m_err, 8'(m_lat)},
                  {vecs[i].exp_res, vecs[i].exp_co, vecs[i].exp_err, 8'(vecs[i].exp_lat)});
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, 1'b0, $sformatf("vec%0d", i));
        end

        // start held high throughout the operation: exactly one done
        run_op(2'd2, 16'h00F0, 16'h0000, 4'd3, 1'b1, "hold_shl");
        run_op(2'd0, 16'h7FFF, 16'h0001, 4'd0, 1'b1, "hold_add");

        // reset while in HI aborts with no done
        run_op(2'd0, 16'hFFFF, 16'h0002, 4'd0, 1'b0, "pre_rst");
        begin
            int d0;
            start = 1'b1; op_sel = 2'd0; opnd_a = 16'h1000; opnd_b = 16'h2000;
            @(posedge Clk);
            d0 = done_cnt;
            @(negedge Clk);
            start = 1'b0;
            @(negedge Clk);
            check("rst busy", ready, 0);
            Reset = 1'b1;
            @(negedge Clk);
            check("rst state", {ready, done, co16, z16, neg16, err}, 6'b100100);
            check("rst result", result, 16'h0000);
            Reset = 1'b0;
            repeat (4) @(negedge Clk);
            check("rst no_done", done_cnt - d0, 0);
            check("rst hold", result, 16'h0000);
        end

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                   4'($urandom_range(0, 15)), 1'b0, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
